// File: rtl/pacman_video_pkg.sv
// Shared video constants and the packed pixel colour type for the map renderer.
package pacman_video_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned MAP_COLS = 20;
   localparam int unsigned MAP_ROWS = 15;
   localparam int unsigned IDX_W    = 9;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

endpackage

// File: rtl/map_addr_gen.sv
// Combinational tile index for a screen pixel: row*20 + col, plus an in-range flag.
module map_addr_gen
   import pacman_video_pkg::*;
#(
   parameter int unsigned TILE_SHIFT = 5
) (
   input  logic [9:0]       draw_x_i,
   input  logic [9:0]       draw_y_i,
   input  logic             blank_n_i,
   output logic [IDX_W-1:0] tile_idx_o,
   output logic             in_range_o
);

   logic [3:0]       row;
   logic [4:0]       col;
   logic [IDX_W-1:0] idx;

   always_comb begin
      row = 4'(draw_y_i >> TILE_SHIFT);
      col = 5'(draw_x_i >> TILE_SHIFT);
      // row * 20 as shift-add
      idx = ({5'b0, row} << 4) + ({5'b0, row} << 2) + {4'b0, col};
      in_range_o = blank_n_i && (draw_x_i < 10'(H_ACTIVE)) && (draw_y_i < 10'(V_ACTIVE));
      tile_idx_o = in_range_o ? idx : '0;
   end

endmodule

// File: rtl/map_pixel_fetch.sv
// Three-stage map pixel fetch: address register, external RAM read, colour register
// with a pellet colour that blinks every 16 frames.
module map_pixel_fetch
   import pacman_video_pkg::*;
#(
   parameter int unsigned TILE_SHIFT = 5,
   parameter logic [23:0] PELLET_KEY = 24'hFFB8AE
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        blank_n,
   input  logic        vs_n,
   output logic [18:0] ram_addr,
   input  logic [23:0] ram_data,
   output logic [7:0]  Red,
   output logic [7:0]  Green,
   output logic [7:0]  Blue,
   output logic        pix_valid
);

   logic [IDX_W-1:0] tile_idx;
   logic             in_range;

   logic [18:0] addr_q, addr_d;
   logic [2:0]  valid_q, valid_d;
   rgb_t        rgb_q, rgb_d;
   logic [4:0]  frame_q, frame_d;
   logic        vs_q, vs_d;
   logic        armed_q, armed_d;
   logic        vs_fall;
   logic        blink_off;

   map_addr_gen #(
      .TILE_SHIFT(TILE_SHIFT)
   ) u_addr_gen (
      .draw_x_i   (DrawX),
      .draw_y_i   (DrawY),
      .blank_n_i  (blank_n),
      .tile_idx_o (tile_idx),
      .in_range_o (in_range)
   );

   always_comb begin
      addr_d  = {10'b0, tile_idx};
      valid_d = {valid_q[1:0], in_range};

      // armed_q masks a vs_n that is already low when reset releases
      vs_d      = vs_n;
      armed_d   = 1'b1;
      vs_fall   = armed_q && vs_q && !vs_n;
      frame_d   = frame_q + {4'b0, vs_fall};
      blink_off = frame_q[4];

      // valid_q[1] lines up with ram_data answering the stage-1 address
      rgb_d = '0;
      if (valid_q[1]) begin
         if ((ram_data == PELLET_KEY) && blink_off) begin
            rgb_d = '0;
         end else begin
            rgb_d = rgb_t'(ram_data);
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         addr_q  <= '0;
         valid_q <= '0;
         rgb_q   <= '0;
         frame_q <= '0;
         vs_q    <= 1'b1;
         armed_q <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         valid_q <= valid_d;
         rgb_q   <= rgb_d;
         frame_q <= frame_d;
         vs_q    <= vs_d;
         armed_q <= armed_d;
      end
   end

   assign ram_addr  = addr_q;
   assign Red       = rgb_q.r;
   assign Green     = rgb_q.g;
   assign Blue      = rgb_q.b;
   assign pix_valid = valid_q[2];

endmodule

// File: tb/tb_map_pixel_fetch.sv
// Randomised bench for map_pixel_fetch against a per-pixel behavioural model.
module tb_map_pixel_fetch;

   localparam logic [23:0] KEY = 24'hFFB8AE;

   logic        Clk;
   logic        Reset_n;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        blank_n;
   logic        vs_n;
   logic [18:0] ram_addr;
   logic [23:0] ram_data;
   logic [7:0]  Red;
   logic [7:0]  Green;
   logic [7:0]  Blue;
   logic        pix_valid;

   int checks   = 0;
   int failures = 0;

   logic [23:0] mem [0:299];

   // model state
   logic        hv0, hv1;
   int          hi0, hi1;
   int          m_frames;
   logic        m_prev_vs, m_armed;
   logic [18:0] exp_addr;
   logic [23:0] exp_rgb;
   logic        exp_pv;

   map_pixel_fetch dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .DrawX     (DrawX),
      .DrawY     (DrawY),
      .blank_n   (blank_n),
      .vs_n      (vs_n),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .Red       (Red),
      .Green     (Green),
      .Blue      (Blue),
      .pix_valid (pix_valid)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Map RAM with a one-cycle registered read
   always @(posedge Clk) begin
      ram_data <= (ram_addr < 19'd300) ? mem[ram_addr[8:0]] : 24'h0;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model: each sample becomes an address now and a colour two edges later
   initial begin
      forever begin
         @(posedge Clk or negedge Reset_n);
         if (!Reset_n) begin
            hv0 = 0; hv1 = 0; hi0 = 0; hi1 = 0;
            m_frames = 0; m_prev_vs = 1; m_armed = 0;
            exp_addr = 0; exp_rgb = 0; exp_pv = 0;
         end else begin
            logic inr;
            int   idx;
            inr = blank_n && (DrawX < 640) && (DrawY < 480);
            idx = inr ? (int'(DrawY) / 32) * 20 + int'(DrawX) / 32 : 0;
            exp_pv  = hv1;
            exp_rgb = 24'h0;
            if (hv1) exp_rgb = (mem[hi1] == KEY && m_frames >= 16) ? 24'h0 : mem[hi1];
            hv1 = hv0; hi1 = hi0;
            hv0 = inr; hi0 = idx;
            exp_addr = 19'(idx);
            if (m_armed && m_prev_vs && !vs_n) m_frames = (m_frames + 1) % 32;
            m_prev_vs = vs_n;
            m_armed   = 1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge Clk);
         chk("addr", 32'(ram_addr), 32'(exp_addr));
         chk("rgb", 32'({Red, Green, Blue}), 32'(exp_rgb));
         chk("pix_valid", 32'(pix_valid), 32'(exp_pv));
      end
   end

   task automatic cyc(input int x, input int y, input logic b);
      DrawX   = 10'(x);
      DrawY   = 10'(y);
      blank_n = b;
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic vsfall();
      vs_n = 1'b0;
      cyc(0, 0, 1'b0);
      vs_n = 1'b1;
      cyc(0, 0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 300; i++) mem[i] = 24'($urandom);
      mem[0]   = 24'h123456;
      mem[41]  = KEY;
      mem[299] = KEY;
      mem[100] = KEY;

      Reset_n = 1'b0; vs_n = 1'b1; DrawX = 0; DrawY = 0; blank_n = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_rgb", 32'({Red, Green, Blue}), 32'd0);
      chk("rst_pv", 32'(pix_valid), 32'd0);
      Reset_n = 1'b1;

      // directed address / colour pins
      cyc(0, 0, 1'b1);
      chk("addr_0_0", 32'(ram_addr), 32'd0);
      cyc(639, 479, 1'b1);
      chk("addr_639_479", 32'(ram_addr), 32'd299);
      cyc(33, 64, 1'b1);
      chk("addr_33_64", 32'(ram_addr), 32'd41);
      chk("rgb_word0", 32'({Red, Green, Blue}), 32'h123456);
      chk("pv_word0", 32'(pix_valid), 32'd1);
      cyc(700, 0, 1'b1);
      chk("addr_x700", 32'(ram_addr), 32'd0);
      chk("rgb_pellet_on", 32'({Red, Green, Blue}), 32'hFFB8AE);
      cyc(10, 10, 1'b0);
      chk("addr_blank", 32'(ram_addr), 32'd0);
      chk("rgb_41", 32'({Red, Green, Blue}), 32'hFFB8AE);
      cyc(0, 0, 1'b0);
      chk("pv_x700", 32'(pix_valid), 32'd0);
      chk("rgb_x700", 32'({Red, Green, Blue}), 32'd0);
      cyc(0, 0, 1'b0);
      chk("pv_blank", 32'(pix_valid), 32'd0);

      // blink: vs_n low across reset release must not count
      vs_n = 1'b0; Reset_n = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      cyc(0, 0, 1'b0);
      cyc(0, 0, 1'b0);
      vs_n = 1'b1;
      cyc(0, 0, 1'b0);
      repeat (15) vsfall();
      cyc(639, 479, 1'b1); cyc(0, 0, 1'b0); cyc(0, 0, 1'b0);
      chk("blink_15", 32'({Red, Green, Blue}), 32'hFFB8AE);
      vsfall();
      cyc(639, 479, 1'b1); cyc(0, 0, 1'b0); cyc(0, 0, 1'b0);
      chk("blink_16", 32'({Red, Green, Blue}), 32'h000000);
      chk("blink_16_pv", 32'(pix_valid), 32'd1);
      repeat (16) vsfall();
      cyc(639, 479, 1'b1); cyc(0, 0, 1'b0); cyc(0, 0, 1'b0);
      chk("blink_32", 32'({Red, Green, Blue}), 32'hFFB8AE);

      // random traffic including vsync edges coinciding with pixels
      repeat (2000) begin
         if ($urandom_range(0, 19) == 0) vs_n = ~vs_n;
         cyc(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
             $urandom_range(0, 7) != 0);
      end

      // reset mid-stream
      vs_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) begin
            DrawX = 10'($urandom_range(0, 639)); DrawY = 10'($urandom_range(0, 479));
            blank_n = 1'b1;
            @(posedge Clk);
            #3 Reset_n = 1'b0;
            #1;
            chk("midrst_addr", 32'(ram_addr), 32'd0);
            chk("midrst_rgb", 32'({Red, Green, Blue}), 32'd0);
            chk("midrst_pv", 32'(pix_valid), 32'd0);
            @(negedge Clk);
            #2 Reset_n = 1'b1;
         end else begin
            cyc(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1);
            if (i == 11) chk("post_rst_pv", 32'(pix_valid), 32'd0);
         end
      end
      repeat (4) cyc(0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/map_pixel_fetch.md
MAP_PIXEL_FETCH -- requirements
Module: map_pixel_fetch

Interface
REQ-001 SHALL have parameter TILE_SHIFT, default 5, meaning log2 of the square tile edge in pixels (32x32 tiles).
REQ-002 SHALL have parameter PELLET_KEY, default 24'hFFB8AE, meaning the map colour that blinks.
REQ-003 SHALL have port Clk, input, 1, the single system clock; every register is clocked on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port DrawX, input, 10, current pixel column from the VGA controller.
REQ-006 SHALL have port DrawY, input, 10, current pixel row from the VGA controller.
REQ-007 SHALL have port blank_n, input, 1, high during the active display region.
REQ-008 SHALL have port vs_n, input, 1, VGA vertical sync, active low.
REQ-009 SHALL have port ram_addr, output, 19, read address to the map frame RAM (registered).
REQ-010 SHALL have port ram_data, input, 24, map RAM read data, valid one cycle after ram_addr.
REQ-011 SHALL have port Red, Green, Blue, output, 8 each, registered pixel colour.
REQ-012 SHALL have port pix_valid, output, 1, high when Red/Green/Blue carry a map pixel.

Function
REQ-013 SHALL treat a pixel as in-range when blank_n=1, DrawX<640 and DrawY<480.
REQ-014 Stage 1 SHALL register ram_addr = (DrawY>>TILE_SHIFT)*20 + (DrawX>>TILE_SHIFT), zero-extended to 19 bits (range 0..299).
REQ-015 The multiply by 20 SHALL be shift-add ((row<<4)+(row<<2)); row is 4 bits (0..14), col 5 bits (0..19).
REQ-016 For out-of-range pixels, ram_addr SHALL be driven to 0.
REQ-017 A 3-bit valid shift register SHALL track in-range status alongside the address pipeline.
REQ-018 Stage 2 SHALL account for the RAM's one-cycle registered read; no register on ram_data is added in stage 2.
REQ-019 Stage 3 SHALL register {Red,Green,Blue} from ram_data and assert pix_valid, exactly 3 Clk cycles after DrawX/DrawY are sampled.
REQ-020 When the tracked valid is 0 at stage 3, Red/Green/Blue SHALL be 0 and pix_valid SHALL be 0.
REQ-021 When ram_data == PELLET_KEY and blink_off=1, the colour SHALL be replaced by 24'h000000 while pix_valid stays 1.
REQ-022 A registered copy of vs_n SHALL detect the falling edge; each falling edge SHALL increment a 5-bit frame counter, wrapping 31->0.
REQ-023 blink_off SHALL equal frame counter bit 4 (16 frames on, 16 off).
REQ-024 Simultaneous vs_n falling edge and in-range pixel SHALL both be processed in the same cycle without interaction.
REQ-025 The pipeline SHALL run every cycle with no stall; a new pixel is accepted each Clk.

Reset
REQ-026 While Reset_n=0: ram_addr=0, Red/Green/Blue=0, pix_valid=0, valid pipeline=0, frame counter=0, vs_n delay register=1.
REQ-027 Reset asserted mid-line SHALL clear all in-flight pixels immediately (asynchronously); the first valid output after release appears 3 cycles after the first in-range sample.
REQ-028 A vs_n already low at reset release SHALL NOT count as a falling edge.

Structure
REQ-029 Package pacman_video_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, MAP_COLS=20, MAP_ROWS=15, and the rgb_t type (three 8-bit fields).
REQ-030 Tile-index arithmetic SHALL be a combinational sub-module, map_addr_gen (DrawX, DrawY -> 9-bit index plus in-range flag).
REQ-031 The frame counter and the pipeline SHALL live in map_pixel_fetch.

Verification
REQ-032 Input DrawX=0, DrawY=0, blank_n=1 -> ram_addr=0 after 1 cycle; RGB equals the model RAM word 0, pix_valid=1, after 3 cycles.
REQ-033 Input DrawX=639, DrawY=479 -> ram_addr=299; DrawX=33, DrawY=64 -> ram_addr=41.
REQ-034 Input blank_n=0 or DrawX=700 -> ram_addr=0; 3 cycles later pix_valid=0 and RGB=0.
REQ-035 Map word = PELLET_KEY: after 15 vs_n falling edges the output is FFB8AE; after the 16th it is 000000; after the 32nd it is FFB8AE again (counter wrap).
REQ-036 Stream of 20 consecutive in-range pixels, then Reset_n pulsed low on cycle 10 -> all outputs 0 immediately; no stale pixel after release.
